// File: rtl/adc_measure.sv
// Windowed measurement stage for the 8-bit ADC sample stream.
// Reports max, min, peak-to-peak, mean, rising-crossing count and crossing period once per window.
module adc_measure #(
    parameter int WINDOW_LOG2 = 20,
    parameter int HYST        = 4
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        Sample_Valid,
    input  logic [7:0]  Sample_Data,
    input  logic [7:0]  Trigger_Gate,
    output logic [7:0]  Vmax,
    output logic [7:0]  Vmin,
    output logic [7:0]  Vpp,
    output logic [7:0]  Vavg,
    output logic [15:0] Edge_Count,
    output logic [23:0] Period,
    output logic        Meas_Valid
);
    localparam int SW = 8 + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {ST_INIT, ST_LOW, ST_HIGH} state_t;

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [7:0]             max_q, max_d, min_q, min_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic [15:0]            edges_q, edges_d;
    logic [23:0]            gap_q, gap_d, last_per_q, last_per_d;
    logic                   seen_q, seen_d;

    logic [7:0]  vmax_q, vmax_d, vmin_q, vmin_d, vpp_q, vpp_d, vavg_q, vavg_d;
    logic [15:0] ecnt_q, ecnt_d;
    logic [23:0] per_q, per_d;
    logic        mv_q, mv_d;

    // Thresholds: hi clamps at 255, lo at 0 (difference held in 10-bit two's complement).
    logic [8:0] hi_sum;
    logic [9:0] lo_diff;
    logic [7:0] hi_th, lo_th;
    assign hi_sum  = {1'b0, Trigger_Gate} + 9'(HYST);
    assign lo_diff = {2'b00, Trigger_Gate} - 10'(HYST);
    assign hi_th   = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    assign lo_th   = lo_diff[9] ? 8'h00 : lo_diff[7:0];

    logic          rise;
    logic [7:0]    max_c, min_c;
    logic [SW-1:0] sum_c;
    logic [15:0]   edges_c;
    logic [23:0]   per_c;

    assign rise = Sample_Valid && (state_q == ST_LOW) && (Sample_Data >= hi_th);

    always_comb begin
        max_c   = (Sample_Data > max_q) ? Sample_Data : max_q;
        min_c   = (Sample_Data < min_q) ? Sample_Data : min_q;
        sum_c   = sum_q + SW'(Sample_Data);
        edges_c = (rise && edges_q != 16'hFFFF) ? edges_q + 16'd1 : edges_q;
        per_c   = last_per_q;
        if (rise && seen_q)
            per_c = (gap_q == 24'hFF_FFFF) ? gap_q : gap_q + 24'd1;

        state_d    = state_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        min_d      = min_q;
        sum_d      = sum_q;
        edges_d    = edges_q;
        gap_d      = gap_q;
        last_per_d = last_per_q;
        seen_d     = seen_q;
        vmax_d     = vmax_q;
        vmin_d     = vmin_q;
        vpp_d      = vpp_q;
        vavg_d     = vavg_q;
        ecnt_d     = ecnt_q;
        per_d      = per_q;
        mv_d       = 1'b0;

        if (Sample_Valid) begin
            case (state_q)
                ST_INIT: state_d = (Sample_Data >= Trigger_Gate) ? ST_HIGH : ST_LOW;
                ST_LOW:  if (rise) state_d = ST_HIGH;
                ST_HIGH: if (Sample_Data <= lo_th) state_d = ST_LOW;
                default: state_d = ST_INIT;
            endcase

            if (rise)
                gap_d = '0;
            else if (gap_q != 24'hFF_FFFF)
                gap_d = gap_q + 24'd1;
            last_per_d = per_c;
            seen_d     = seen_q | rise;
            cnt_d      = cnt_q + 1'b1;

            if (cnt_q == CNT_LAST) begin
                vmax_d  = max_c;
                vmin_d  = min_c;
                vpp_d   = max_c - min_c;
                vavg_d  = sum_c[SW-1:WINDOW_LOG2];
                ecnt_d  = edges_c;
                per_d   = (edges_c >= 16'd2) ? per_c : '0;
                mv_d    = 1'b1;
                max_d   = 8'h00;
                min_d   = 8'hFF;
                sum_d   = '0;
                edges_d = '0;
            end else begin
                max_d   = max_c;
                min_d   = min_c;
                sum_d   = sum_c;
                edges_d = edges_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            max_q      <= 8'h00;
            min_q      <= 8'hFF;
            sum_q      <= '0;
            edges_q    <= '0;
            gap_q      <= '0;
            last_per_q <= '0;
            seen_q     <= 1'b0;
            vmax_q     <= '0;
            vmin_q     <= '0;
            vpp_q      <= '0;
            vavg_q     <= '0;
            ecnt_q     <= '0;
            per_q      <= '0;
            mv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            min_q      <= min_d;
            sum_q      <= sum_d;
            edges_q    <= edges_d;
            gap_q      <= gap_d;
            last_per_q <= last_per_d;
            seen_q     <= seen_d;
            vmax_q     <= vmax_d;
            vmin_q     <= vmin_d;
            vpp_q      <= vpp_d;
            vavg_q     <= vavg_d;
            ecnt_q     <= ecnt_d;
            per_q      <= per_d;
            mv_q       <= mv_d;
        end
    end

    assign Vmax       = vmax_q;
    assign Vmin       = vmin_q;
    assign Vpp        = vpp_q;
    assign Vavg       = vavg_q;
    assign Edge_Count = ecnt_q;
    assign Period     = per_q;
    assign Meas_Valid = mv_q;
endmodule

// File: tb/tb_adc_measure.sv
// Bench for adc_measure: directed scenarios plus randomized traffic against a window-level reference model.
module tb_adc_measure;
    localparam int WL   = 4;
    localparam int WIN  = 1 << WL;
    localparam int HYST = 4;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Sample_Valid = 1'b0;
    logic [7:0]  Sample_Data = '0;
    logic [7:0]  Trigger_Gate = 8'd128;
    logic [7:0]  Vmax, Vmin, Vpp, Vavg;
    logic [15:0] Edge_Count;
    logic [23:0] Period;
    logic        Meas_Valid;
    logic [71:0] res;

    adc_measure #(.WINDOW_LOG2(WL), .HYST(HYST)) dut (
        .clk(clk), .Rst(Rst), .Sample_Valid(Sample_Valid), .Sample_Data(Sample_Data),
        .Trigger_Gate(Trigger_Gate), .Vmax(Vmax), .Vmin(Vmin), .Vpp(Vpp), .Vavg(Vavg),
        .Edge_Count(Edge_Count), .Period(Period), .Meas_Valid(Meas_Valid)
    );

    always #5 clk = ~clk;
    assign res = {Vmax, Vmin, Vpp, Vavg, Edge_Count, Period};

    int checks = 0;
    int fails  = 0;

    // Reference model: window contents as a queue, crossings tracked by global sample index.
    int          win[$];
    int          wedges, lvl, nx, idx, last_x, prev_x;
    logic [71:0] exp_res;
    logic        exp_mv;

    task automatic model_reset();
        win.delete();
        wedges = 0; lvl = -1; nx = 0; idx = 0; last_x = 0; prev_x = 0;
        exp_res = '0; exp_mv = 1'b0;
    endtask

    task automatic model_accept(input int s, input int g);
        int hi, lo, mx, mn, sm, per;
        hi = (g + HYST > 255) ? 255 : g + HYST;
        lo = (g - HYST < 0) ? 0 : g - HYST;
        if (lvl < 0) lvl = (s >= g) ? 1 : 0;
        else if (lvl == 0 && s >= hi) begin
            lvl = 1; wedges++; nx++; prev_x = last_x; last_x = idx;
        end else if (lvl == 1 && s <= lo) lvl = 0;
        idx++;
        win.push_back(s);
        if (win.size() == WIN) begin
            mx = 0; mn = 255; sm = 0;
            foreach (win[i]) begin
                if (win[i] > mx) mx = win[i];
                if (win[i] < mn) mn = win[i];
                sm += win[i];
            end
            per = (wedges >= 2) ? last_x - prev_x : 0;
            exp_res = {8'(mx), 8'(mn), 8'(mx - mn), 8'(sm / WIN),
                       16'((wedges > 65535) ? 65535 : wedges), 24'(per)};
            exp_mv = 1'b1;
            win.delete();
            wedges = 0;
        end
    endtask

    // Drives one cycle and advances the model to what the DUT should show just after the edge.
    task automatic step(input logic rst_n, input logic v, input logic [7:0] d, input logic [7:0] g);
        Rst = rst_n; Sample_Valid = v; Sample_Data = d; Trigger_Gate = g;
        @(posedge clk); #1;
        exp_mv = 1'b0;
        if (!rst_n) model_reset();
        else if (v) model_accept(int'(d), int'(g));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            step(i >= 3, 1'b0, 8'($urandom), 8'd128);
            checks++;
            if (Meas_Valid !== 1'b0) begin fails++; $display("FAIL reset_mv cyc %0d: got %b want 0", i, Meas_Valid); end
            checks++;
            if (res !== 72'd0) begin fails++; $display("FAIL reset_outs cyc %0d: got %h want 0", i, res); end
        end
    endtask

    task automatic test_constant();
        int pulses = 0;
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b1, 8'd100, 8'd128);
            if (Meas_Valid === 1'b1) pulses++;
            checks++;
            if (Meas_Valid !== exp_mv) begin fails++; $display("FAIL const_mv cyc %0d: got %b want %b", i, Meas_Valid, exp_mv); end
            checks++;
            if (res !== exp_res) begin fails++; $display("FAIL const_res cyc %0d: got %h want %h", i, res, exp_res); end
        end
        step(1'b1, 1'b0, 8'd0, 8'd128);
        checks++;
        if (Meas_Valid !== 1'b0) begin fails++; $display("FAIL const_mv_drop: got %b want 0", Meas_Valid); end
        checks++;
        if (pulses != 1) begin fails++; $display("FAIL const_pulses: got %0d want 1", pulses); end
        checks++;
        if (res !== {8'd100, 8'd100, 8'd0, 8'd100, 16'd0, 24'd0}) begin
            fails++; $display("FAIL const_values: got %h want 646400640000000000", res);
        end
    endtask

    task automatic test_square(input bit gaps);
        int n = gaps ? 2 * WIN : WIN;
        int k = 0;
        int pulse_at = -1;
        logic [7:0] sq [4] = '{8'd50, 8'd50, 8'd200, 8'd200};
        for (int i = 0; i < n; i++) begin
            if (!gaps || (i % 2 == 0)) begin
                step(1'b1, 1'b1, sq[k % 4], 8'd128);
                k++;
            end else
                step(1'b1, 1'b0, 8'($urandom), 8'd128);
            if (Meas_Valid === 1'b1) pulse_at = i;
            checks++;
            if (Meas_Valid !== exp_mv) begin fails++; $display("FAIL square_mv gaps=%0d cyc %0d: got %b want %b", gaps, i, Meas_Valid, exp_mv); end
            checks++;
            if (res !== exp_res) begin fails++; $display("FAIL square_res gaps=%0d cyc %0d: got %h want %h", gaps, i, res, exp_res); end
        end
        checks++;
        if (res !== {8'd200, 8'd50, 8'd150, 8'd125, 16'd4, 24'd4}) begin
            fails++; $display("FAIL square_values gaps=%0d: got %h want c83296 7d 0004 000004", gaps, res);
        end
        checks++;
        if (pulse_at != (gaps ? n - 2 : n - 1)) begin
            fails++; $display("FAIL square_pulse_pos gaps=%0d: got %0d want %0d", gaps, pulse_at, gaps ? n - 2 : n - 1);
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b1, (i % 2) ? 8'd130 : 8'd127, 8'd128);
            checks++;
            if (Meas_Valid !== exp_mv) begin fails++; $display("FAIL hyst_mv cyc %0d: got %b want %b", i, Meas_Valid, exp_mv); end
        end
        checks++;
        if (res !== {8'd130, 8'd127, 8'd3, 8'd128, 16'd0, 24'd0}) begin
            fails++; $display("FAIL hyst_values: got %h want 827f0380 0000 000000", res);
        end
        checks++;
        if (res !== exp_res) begin fails++; $display("FAIL hyst_model: got %h want %h", res, exp_res); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'($urandom), 8'd128);
        step(1'b0, 1'b1, 8'd5, 8'd128);
        checks++;
        if (res !== 72'd0 || Meas_Valid !== 1'b0) begin fails++; $display("FAIL midreset_clear: got %h mv %b want 0", res, Meas_Valid); end
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b1, 8'd100, 8'd128);
            if (Meas_Valid === 1'b1) pulses++;
            checks++;
            if (Meas_Valid !== exp_mv) begin fails++; $display("FAIL midreset_mv cyc %0d: got %b want %b", i, Meas_Valid, exp_mv); end
        end
        checks++;
        if (pulses != 1) begin fails++; $display("FAIL midreset_pulses: got %0d want 1", pulses); end
        checks++;
        if (res !== {8'd100, 8'd100, 8'd0, 8'd100, 16'd0, 24'd0}) begin
            fails++; $display("FAIL midreset_values: got %h want 646400640000000000", res);
        end
    endtask

    // Gate near both rails exercises threshold clamping.
    task automatic test_clamp();
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'b1, 1'b1, (i % 2) ? 8'd255 : 8'd0, (i < WIN) ? 8'd253 : 8'd2);
            checks++;
            if (Meas_Valid !== exp_mv) begin fails++; $display("FAIL clamp_mv cyc %0d: got %b want %b", i, Meas_Valid, exp_mv); end
            checks++;
            if (res !== exp_res) begin fails++; $display("FAIL clamp_res cyc %0d: got %h want %h", i, res, exp_res); end
        end
    endtask

    task automatic test_random();
        logic [7:0] g = 8'($urandom);
        for (int i = 0; i < 12 * WIN; i++) begin
            if ($urandom_range(0, 15) == 0) g = 8'($urandom);
            step(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), g);
            checks++;
            if (Meas_Valid !== exp_mv) begin fails++; $display("FAIL random_mv cyc %0d: got %b want %b", i, Meas_Valid, exp_mv); end
            checks++;
            if (res !== exp_res) begin fails++; $display("FAIL random_res cyc %0d: got %h want %h", i, res, exp_res); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_constant();
        test_square(1'b0);
        test_hysteresis();
        test_square(1'b1);
        test_reset_mid();
        test_clamp();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/adc_measure.md
# adc_measure

Streaming measurement stage for the ADC capture path. It sits downstream of the ADC driver, in parallel with the waveform renderer, and consumes the same 8-bit sample stream. Over a fixed window of accepted samples it computes maximum, minimum, peak-to-peak, mean, rising-crossing count and crossing period. Results are latched once per window, with a one-cycle valid pulse, for the on-screen readout logic.

## Interface
- WINDOW_LOG2, 20: window length is 2^WINDOW_LOG2 accepted samples; legal range 2..24.
- HYST, 4: hysteresis half-width, in LSB, around Trigger_Gate; legal range 0..127.

- clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-low reset.
- Sample_Valid  in  1  Sample_Data accepted in every cycle where this is high.
- Sample_Data  in  8  unsigned ADC sample.
- Trigger_Gate  in  8  crossing threshold; sampled every cycle.
- Vmax  out  8  window maximum.
- Vmin  out  8  window minimum.
- Vpp  out  8  Vmax − Vmin.
- Vavg  out  8  window sum >> WINDOW_LOG2 (truncating).
- Edge_Count  out  16  rising crossings in window; saturates at 0xFFFF.
- Period  out  24  samples between the last two rising crossings; 0 if the window had fewer than 2 crossings.
- Meas_Valid  out  1  one-cycle pulse when all result outputs update.

## Operation
- Accumulators:
  - sample counter, WINDOW_LOG2 bits
  - run_max, init 0
  - run_min, init 255
  - run_sum, 8+WINDOW_LOG2 bits
  - run_edges, 16-bit saturating
  - gap counter, 24-bit saturating; counts accepted samples since last rising crossing
  - last_period, 24 bits, init 0
- Thresholds:
  - hi_th = min(Trigger_Gate + HYST, 255), computed at 9 bits then clamped.
  - lo_th = max(Trigger_Gate − HYST, 0), computed signed then clamped.
- Crossing FSM, advances only on accepted samples:
  - ST_INIT: sample ≥ Trigger_Gate → ST_HIGH, otherwise → ST_LOW. No crossing counted.
  - ST_LOW: sample ≥ hi_th → ST_HIGH and a rising crossing is recorded.
  - ST_HIGH: sample ≤ lo_th → ST_LOW.
- On a rising crossing:
  - run_edges increments.
  - If a prior crossing has occurred since reset, last_period ← gap + 1.
  - gap ← 0.
- On any other accepted sample, gap increments, saturating.
- The FSM state, gap and last_period persist across window boundaries. Only reset clears them.
- Every accepted sample updates max, min, sum and edges using the current sample combinationally. Results therefore include the sample accepted in that cycle.
- Final sample, when sample counter = 2^WINDOW_LOG2 − 1:
  - Outputs latch the combined values, including the final sample and any crossing it produces.
  - Period ← updated last_period if the window's edge total ≥ 2, else 0.
  - Accumulators reload to their init values and the counter wraps to 0.
- Sample_Valid low: no state changes and outputs hold.
- Outputs change only at window completion.

## Timing
- Reset (Rst=0 at a clock edge):
  - All outputs 0, Meas_Valid 0.
  - FSM → ST_INIT; all accumulators at their init values.
  - Applies mid-window; the partial window is discarded with no Meas_Valid.
- Latency: final sample accepted in cycle N → outputs and Meas_Valid=1 in cycle N+1. Meas_Valid is 0 in N+2 unless another window completes.
- Throughput: one sample per cycle, no back-pressure.
- Minimum spacing between Meas_Valid pulses is 2^WINDOW_LOG2 cycles.
- Trigger_Gate changes take effect for the sample accepted in the same cycle.
- A crossing on the first sample after a boundary counts toward the new window.

## Test plan
- Reset: hold Rst=0 for 3 cycles, then release with no samples → all outputs 0 and Meas_Valid never asserts.
- Constant input (WINDOW_LOG2=4, HYST=4, Trigger_Gate=128): 16 samples of 100 → Vmax=Vmin=Vavg=100, Vpp=0, Edge_Count=0, Period=0. Meas_Valid is a single pulse in the cycle after the 16th sample.
- Square wave: repeating 50,50,200,200 for 16 samples → Edge_Count=4, Period=4, Vmax=200, Vmin=50, Vpp=150, Vavg=125.
- Hysteresis: samples alternating 127,130 with gate 128 → Edge_Count=0, Period=0, Vpp=3, Vavg=128.
- Valid gaps: square wave from the square-wave scenario with Sample_Valid high every other cycle → identical results. Meas_Valid occurs one cycle after the 16th accepted sample (cycle 32).
- Reset mid-window: feed 8 samples, then Rst=0 for 1 cycle, then 16 constant-100 samples → no pulse for the partial window. One pulse with the constant-100 results after the 16th post-reset sample.
